// File: rtl/vga_timing_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_pkg : shared VGA 640x480@60 timing defaults and axis phase type
// Revision 1.0
// ----------------------------------------------------------------------------
package vga_timing_pkg;

  localparam int CNT_W = 10;
  localparam int COL_W = 10;

  localparam int H_ACTIVE_DEF = 640;
  localparam int H_FP_DEF     = 16;
  localparam int H_SYNC_DEF   = 96;
  localparam int H_BP_DEF     = 48;
  localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;

  localparam int V_ACTIVE_DEF = 480;
  localparam int V_FP_DEF     = 10;
  localparam int V_SYNC_DEF   = 2;
  localparam int V_BP_DEF     = 33;
  localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  localparam int PIX_LAT_DEF  = 1;
  localparam int PIX_LAT_MAX  = 4;

  typedef logic [CNT_W-1:0] cnt_t;
  typedef logic [COL_W-1:0] col_t;

  typedef enum logic [3:0] {
    PH_ACTIVE = 4'b0001,
    PH_FP     = 4'b0010,
    PH_SYNC   = 4'b0100,
    PH_BP     = 4'b1000
  } phase_e;

  // Phase advances on the last count of the current region, so the phase
  // always describes the region the counter currently sits in.
  function automatic phase_e phase_next(
    input phase_e cur,
    input cnt_t   cnt,
    input cnt_t   last_active,
    input cnt_t   last_fp,
    input cnt_t   last_sync,
    input cnt_t   last_total
  );
    phase_e nxt;
    nxt = cur;
    case (cur)
      PH_ACTIVE: if (cnt == last_active) nxt = PH_FP;
      PH_FP:     if (cnt == last_fp)     nxt = PH_SYNC;
      PH_SYNC:   if (cnt == last_sync)   nxt = PH_BP;
      PH_BP:     if (cnt == last_total)  nxt = PH_ACTIVE;
      default:                           nxt = PH_ACTIVE;
    endcase
    return nxt;
  endfunction

endpackage
`default_nettype wire

// File: rtl/vga_sync_delay.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_sync_delay : DEPTH-stage shift register for sync/active side-band flags
// Revision 1.0
// ----------------------------------------------------------------------------
module vga_sync_delay #(
  parameter int               DEPTH   = 1,
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] pipe_q [DEPTH];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        pipe_q[i] <= RST_VAL;
      end
    end else begin
      pipe_q[0] <= d_i;
      for (int i = 1; i < DEPTH; i++) begin
        pipe_q[i] <= pipe_q[i-1];
      end
    end
  end

  assign q_o = pipe_q[DEPTH-1];

endmodule
`default_nettype wire

// File: rtl/vga_timing_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// vga_timing_ctrl : VGA raster timing, pixel request and latency-matched DAC out
// Revision 1.0
// ----------------------------------------------------------------------------
module vga_timing_ctrl
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = H_ACTIVE_DEF,
  parameter int H_FP     = H_FP_DEF,
  parameter int H_SYNC   = H_SYNC_DEF,
  parameter int H_BP     = H_BP_DEF,
  parameter int V_ACTIVE = V_ACTIVE_DEF,
  parameter int V_FP     = V_FP_DEF,
  parameter int V_SYNC   = V_SYNC_DEF,
  parameter int V_BP     = V_BP_DEF,
  parameter int PIX_LAT  = PIX_LAT_DEF
) (
  input  logic       iVGA_CLK,
  input  logic       iRST_n,
  input  logic [9:0] iRed,
  input  logic [9:0] iGreen,
  input  logic [9:0] iBlue,
  output logic [9:0] oVGA_X,
  output logic [9:0] oVGA_Y,
  output logic [9:0] oVGA_R,
  output logic [9:0] oVGA_G,
  output logic [9:0] oVGA_B,
  output logic       oVGA_HS,
  output logic       oVGA_VS,
  output logic       oVGA_BLANK_n,
  output logic       oFRAME_START
);

  localparam int H_LEN = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_LEN = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam cnt_t H_LAST_ACT  = cnt_t'(H_ACTIVE - 1);
  localparam cnt_t H_LAST_FP   = cnt_t'(H_ACTIVE + H_FP - 1);
  localparam cnt_t H_LAST_SYNC = cnt_t'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam cnt_t H_LAST      = cnt_t'(H_LEN - 1);

  localparam cnt_t V_LAST_ACT  = cnt_t'(V_ACTIVE - 1);
  localparam cnt_t V_LAST_FP   = cnt_t'(V_ACTIVE + V_FP - 1);
  localparam cnt_t V_LAST_SYNC = cnt_t'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam cnt_t V_LAST      = cnt_t'(V_LEN - 1);

  localparam int         DLY_DEPTH = PIX_LAT + 1;
  localparam int         DLY_W     = 3;
  // Flag order {hs_n, vs_n, active}: idle is sync released, picture blanked.
  localparam logic [2:0] DLY_IDLE  = 3'b110;

  cnt_t   h_cnt_q, h_cnt_d;
  cnt_t   v_cnt_q, v_cnt_d;
  logic   h_wrap, v_wrap;
  phase_e h_phase_q, h_phase_d;
  phase_e v_phase_q, v_phase_d;

  logic   active_raw, hs_n_raw, vs_n_raw;
  cnt_t   x_q, x_d;
  cnt_t   y_q, y_d;
  logic   fs_q, fs_d;

  logic [DLY_W-1:0] dly_in, dly_out;
  logic   dly_hs_n, dly_vs_n, dly_active;

  col_t   r_q, r_d;
  col_t   g_q, g_d;
  col_t   b_q, b_d;
  logic   hs_q, vs_q, blank_n_q;

  always_comb begin
    h_wrap  = (h_cnt_q == H_LAST);
    v_wrap  = (v_cnt_q == V_LAST);
    h_cnt_d = h_wrap ? '0 : h_cnt_q + cnt_t'(1);
    v_cnt_d = v_cnt_q;
    if (h_wrap) begin
      v_cnt_d = v_wrap ? '0 : v_cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_cnt_q <= '0;
      v_cnt_q <= '0;
    end else begin
      h_cnt_q <= h_cnt_d;
      v_cnt_q <= v_cnt_d;
    end
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      h_phase_q <= PH_ACTIVE;
      v_phase_q <= PH_ACTIVE;
    end else begin
      h_phase_q <= h_phase_d;
      v_phase_q <= v_phase_d;
    end
  end

  // The vertical phase only moves on the last clock of a line.
  always_comb begin
    h_phase_d = phase_next(h_phase_q, h_cnt_q, H_LAST_ACT, H_LAST_FP,
                           H_LAST_SYNC, H_LAST);
    v_phase_d = v_phase_q;
    if (h_wrap) begin
      v_phase_d = phase_next(v_phase_q, v_cnt_q, V_LAST_ACT, V_LAST_FP,
                             V_LAST_SYNC, V_LAST);
    end
  end

  always_comb begin
    active_raw = (h_phase_q == PH_ACTIVE) && (v_phase_q == PH_ACTIVE);
    hs_n_raw   = (h_phase_q != PH_SYNC);
    vs_n_raw   = (v_phase_q != PH_SYNC);
    x_d        = active_raw ? h_cnt_q : '0;
    y_d        = active_raw ? v_cnt_q : '0;
    fs_d       = (h_cnt_q == '0) && (v_cnt_q == '0);
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      x_q  <= '0;
      y_q  <= '0;
      fs_q <= 1'b0;
    end else begin
      x_q  <= x_d;
      y_q  <= y_d;
      fs_q <= fs_d;
    end
  end

  assign dly_in = {hs_n_raw, vs_n_raw, active_raw};

  // Output of the last stage lines up with the cycle in which the pattern
  // generator's colour for the same pixel is valid on iRed/iGreen/iBlue.
  vga_sync_delay #(
    .DEPTH   (DLY_DEPTH),
    .WIDTH   (DLY_W),
    .RST_VAL (DLY_IDLE)
  ) u_sync_delay (
    .clk_i  (iVGA_CLK),
    .rst_ni (iRST_n),
    .d_i    (dly_in),
    .q_o    (dly_out)
  );

  assign {dly_hs_n, dly_vs_n, dly_active} = dly_out;

  always_comb begin
    r_d = dly_active ? iRed   : '0;
    g_d = dly_active ? iGreen : '0;
    b_d = dly_active ? iBlue  : '0;
  end

  always_ff @(posedge iVGA_CLK or negedge iRST_n) begin
    if (!iRST_n) begin
      r_q       <= '0;
      g_q       <= '0;
      b_q       <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
    end else begin
      r_q       <= r_d;
      g_q       <= g_d;
      b_q       <= b_d;
      hs_q      <= dly_hs_n;
      vs_q      <= dly_vs_n;
      blank_n_q <= dly_active;
    end
  end

  assign oVGA_X       = x_q;
  assign oVGA_Y       = y_q;
  assign oFRAME_START = fs_q;
  assign oVGA_R       = r_q;
  assign oVGA_G       = g_q;
  assign oVGA_B       = b_q;
  assign oVGA_HS      = hs_q;
  assign oVGA_VS      = vs_q;
  assign oVGA_BLANK_n = blank_n_q;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_vga_timing_ctrl : scoreboard bench on a reduced raster (25 x 13)
// Revision 1.0
// ----------------------------------------------------------------------------
module tb_vga_timing_ctrl;

  localparam int HA = 16, HF = 2, HSY = 4, HB = 3;
  localparam int HT = HA + HF + HSY + HB;
  localparam int VA = 8, VF = 1, VSY = 2, VB = 2;
  localparam int VT = VA + VF + VSY + VB;
  localparam int FRAME = HT * VT;
  localparam int LAT = 1;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic       bl;
    logic [9:0] r;
    logic [9:0] g;
    logic [9:0] b;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic cmode = 1'b0;
  int   errors = 0;
  int   checks = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  logic [9:0] x1, y1, r1, g1, b1, red1, grn1, blu1;
  logic       hs1, vs1, bl1, fs1;
  logic [9:0] x0, y0, r0, g0, b0, red0, grn0, blu0;
  logic       hs0, vs0, bl0, fs0;
  logic [9:0] x4, y4, r4, g4, b4, red4, grn4, blu4;
  logic       hs4, vs4, bl4, fs4;

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_LAT(LAT)) u_dut (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red1), .iGreen(grn1), .iBlue(blu1),
    .oVGA_X(x1), .oVGA_Y(y1), .oVGA_R(r1), .oVGA_G(g1), .oVGA_B(b1),
    .oVGA_HS(hs1), .oVGA_VS(vs1), .oVGA_BLANK_n(bl1), .oFRAME_START(fs1));

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_LAT(0)) u_dut_lat0 (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red0), .iGreen(grn0), .iBlue(blu0),
    .oVGA_X(x0), .oVGA_Y(y0), .oVGA_R(r0), .oVGA_G(g0), .oVGA_B(b0),
    .oVGA_HS(hs0), .oVGA_VS(vs0), .oVGA_BLANK_n(bl0), .oFRAME_START(fs0));

  vga_timing_ctrl #(.H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB), .PIX_LAT(4)) u_dut_lat4 (
    .iVGA_CLK(clk), .iRST_n(rst_n), .iRed(red4), .iGreen(grn4), .iBlue(blu4),
    .oVGA_X(x4), .oVGA_Y(y4), .oVGA_R(r4), .oVGA_G(g4), .oVGA_B(b4),
    .oVGA_HS(hs4), .oVGA_VS(vs4), .oVGA_BLANK_n(bl4), .oFRAME_START(fs4));

  // Pattern generators: colour = requested coordinate, returned PIX_LAT clocks later.
  logic [9:0] xp1, yp1;
  logic [9:0] xp4 [4];
  logic [9:0] yp4 [4];

  always @(posedge clk) begin
    xp1 <= x1;
    yp1 <= y1;
    xp4[0] <= x4;
    yp4[0] <= y4;
    for (int i = 1; i < 4; i++) begin
      xp4[i] <= xp4[i-1];
      yp4[i] <= yp4[i-1];
    end
  end

  assign red1 = cmode ? 10'd1023 : xp1;
  assign grn1 = cmode ? 10'd1023 : yp1;
  assign blu1 = cmode ? 10'd1023 : (xp1 ^ yp1);
  assign red0 = x0;
  assign grn0 = y0;
  assign blu0 = x0 ^ y0;
  assign red4 = xp4[3];
  assign grn4 = yp4[3];
  assign blu4 = xp4[3] ^ yp4[3];

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({x1, y1, r1, g1, b1} !== 50'd0) begin
      errors++;
      $display("FAIL reset_data got x=%0d y=%0d r=%0d g=%0d b=%0d want all 0", x1, y1, r1, g1, b1);
    end
    checks++;
    if ({hs1, vs1, bl1, fs1} !== 4'b1100) begin
      errors++;
      $display("FAIL reset_ctrl got hs,vs,blank_n,fs=%b want 1100", {hs1, vs1, bl1, fs1});
    end
    checks++;
    if ({hs0, vs0, bl0, hs4, vs4, bl4} !== 6'b110110) begin
      errors++;
      $display("FAIL reset_lat_variants got %b want 110110", {hs0, vs0, bl0, hs4, vs4, bl4});
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fs1, x1, y1} !== {1'b1, 20'd0}) begin
      errors++;
      $display("FAIL first_pixel got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", fs1, x1, y1);
    end
    @(negedge clk);
    checks++;
    if ({fs1, x1, y1} !== {1'b0, 10'd1, 10'd0}) begin
      errors++;
      $display("FAIL second_pixel got fs=%b x=%0d y=%0d want fs=0 x=1 y=0", fs1, x1, y1);
    end
  endtask

  task automatic test_stream();
    exp_t e;
    exp_t got;
    int h, v;
    logic act;
    do_reset();
    sb_q.delete();
    e = '0;
    e.hs = 1'b1;
    e.vs = 1'b1;
    for (int i = 0; i < LAT + 1; i++) sb_q.push_back(e);
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      h = c % HT;
      v = (c / HT) % VT;
      act = (h < HA) && (v < VA);
      checks++;
      if ({x1, y1, fs1} !== {(act ? 10'(h) : 10'd0), (act ? 10'(v) : 10'd0), (h == 0 && v == 0)}) begin
        errors++;
        $display("FAIL coord c=%0d got x=%0d y=%0d fs=%b want x=%0d y=%0d fs=%b",
                 c, x1, y1, fs1, act ? h : 0, act ? v : 0, (h == 0 && v == 0));
      end
      e.hs = !((h >= HA + HF) && (h < HA + HF + HSY));
      e.vs = !((v >= VA + VF) && (v < VA + VF + VSY));
      e.bl = act;
      e.r  = act ? 10'(h) : 10'd0;
      e.g  = act ? 10'(v) : 10'd0;
      e.b  = act ? 10'(h ^ v) : 10'd0;
      sb_q.push_back(e);
      e = sb_q.pop_front();
      got = {hs1, vs1, bl1, r1, g1, b1};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL stream_out c=%0d got hs=%b vs=%b bl=%b r=%0d g=%0d b=%0d want hs=%b vs=%b bl=%b r=%0d g=%0d b=%0d",
                 c, got.hs, got.vs, got.bl, got.r, got.g, got.b, e.hs, e.vs, e.bl, e.r, e.g, e.b);
      end
    end
  endtask

  task automatic test_hsync();
    int first_low = -1;
    int lows = 0;
    do_reset();
    for (int c = 0; c < HT + 3; c++) begin
      @(negedge clk);
      if (!hs1) begin
        lows++;
        if (first_low < 0) first_low = c;
      end
    end
    checks++;
    if (first_low != LAT + 1 + HA + HF) begin
      errors++;
      $display("FAIL hsync_offset got %0d want %0d", first_low, LAT + 1 + HA + HF);
    end
    checks++;
    if (lows != HSY) begin
      errors++;
      $display("FAIL hsync_width got %0d want %0d", lows, HSY);
    end
  endtask

  task automatic test_frame();
    bit found = 0;
    int period = 0, vs_low = 0, bl_hi = 0;
    for (int c = 0; c < FRAME + 2; c++) begin
      @(negedge clk);
      if (fs1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL frame_start_timeout got none want pulse within %0d clocks", FRAME + 2);
    end
    for (int c = 0; c < 2 * FRAME; c++) begin
      if (!vs1) vs_low++;
      if (bl1) bl_hi++;
      period++;
      @(negedge clk);
      if (fs1) break;
    end
    checks++;
    if (period != FRAME) begin
      errors++;
      $display("FAIL frame_period got %0d want %0d", period, FRAME);
    end
    checks++;
    if (vs_low != VSY * HT) begin
      errors++;
      $display("FAIL vsync_low got %0d want %0d", vs_low, VSY * HT);
    end
    checks++;
    if (bl_hi != HA * VA) begin
      errors++;
      $display("FAIL blank_n_high got %0d want %0d", bl_hi, HA * VA);
    end
  endtask

  task automatic test_const_colour();
    bit found = 0;
    int p, h, v;
    logic act;
    cmode = 1'b1;
    @(negedge clk);
    for (int c = 0; c < FRAME + 2; c++) begin
      @(negedge clk);
      if (fs1) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL const_sync_timeout got none want frame start");
    end
    for (int c = 0; c < FRAME; c++) begin
      p = (c - (LAT + 1) + FRAME) % FRAME;
      h = p % HT;
      v = p / HT;
      act = (h < HA) && (v < VA);
      checks++;
      if ({bl1, r1, g1, b1} !== {act, (act ? {3{10'd1023}} : 30'd0)}) begin
        errors++;
        $display("FAIL const_colour c=%0d got bl=%b rgb=%0d/%0d/%0d want bl=%b rgb=%0d",
                 c, bl1, r1, g1, b1, act, act ? 1023 : 0);
      end
      @(negedge clk);
    end
    cmode = 1'b0;
  endtask

  task automatic test_mid_reset();
    bit found = 0;
    for (int c = 0; c < 2 * FRAME; c++) begin
      @(negedge clk);
      if (x1 == 10'd10 && y1 == 10'd5) begin
        found = 1;
        break;
      end
    end
    checks++;
    if (!found || r1 !== 10'd8) begin
      errors++;
      $display("FAIL mid_frame_pre got found=%b r=%0d want found=1 r=8", found, r1);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({x1, y1, r1, g1, b1, hs1, vs1, bl1, fs1} !== {50'd0, 4'b1100}) begin
      errors++;
      $display("FAIL async_reset got x=%0d y=%0d r=%0d hs=%b vs=%b bl=%b fs=%b want 0 0 0 1 1 0 0",
               x1, y1, r1, hs1, vs1, bl1, fs1);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if ({fs1, x1, y1} !== {1'b1, 20'd0}) begin
      errors++;
      $display("FAIL restart got fs=%b x=%0d y=%0d want fs=1 x=0 y=0", fs1, x1, y1);
    end
  endtask

  task automatic test_latency_sweep();
    logic [29:0] rgbt [2][40];
    logic        hst  [2][40];
    logic        blt  [2][40];
    logic        fst  [2];
    int lat_of [2];
    int L, first_low, lows;
    lat_of[0] = 0;
    lat_of[1] = 4;
    do_reset();
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      rgbt[0][c] = {r0, g0, b0};
      rgbt[1][c] = {r4, g4, b4};
      hst[0][c]  = hs0;
      hst[1][c]  = hs4;
      blt[0][c]  = bl0;
      blt[1][c]  = bl4;
      if (c == 0) begin
        fst[0] = fs0;
        fst[1] = fs4;
      end
    end
    for (int k = 0; k < 2; k++) begin
      L = lat_of[k];
      first_low = -1;
      lows = 0;
      for (int c = 0; c < 40; c++) begin
        if (!hst[k][c]) begin
          lows++;
          if (first_low < 0) first_low = c;
        end
      end
      checks++;
      if ({fst[k], blt[k][L], blt[k][L+1]} !== 3'b101) begin
        errors++;
        $display("FAIL lat%0d_blank_align got fs=%b bl[L]=%b bl[L+1]=%b want 1 0 1",
                 L, fst[k], blt[k][L], blt[k][L+1]);
      end
      checks++;
      if (rgbt[k][L+6] !== {10'd5, 10'd0, 10'd5} || rgbt[k][L+5] !== {10'd4, 10'd0, 10'd4}) begin
        errors++;
        $display("FAIL lat%0d_colour_align got rgb[L+5]=%h rgb[L+6]=%h want %h %h",
                 L, rgbt[k][L+5], rgbt[k][L+6], {10'd4, 10'd0, 10'd4}, {10'd5, 10'd0, 10'd5});
      end
      checks++;
      if (first_low != L + 1 + HA + HF) begin
        errors++;
        $display("FAIL lat%0d_hsync_offset got %0d want %0d", L, first_low, L + 1 + HA + HF);
      end
      checks++;
      if (lows != HSY) begin
        errors++;
        $display("FAIL lat%0d_hsync_width got %0d want %0d", L, lows, HSY);
      end
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_hsync();
    test_frame();
    test_const_colour();
    test_mid_reset();
    test_latency_sweep();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout want bench completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
